bcd_digit_to_bin: RTL and testbench
===================================

// Module: bcd_digit_to_bin
// PURPOSE
//   Decimal-digit entry decoder: collects BCD digits, most significant first, and
//   reassembles them into one binary value (e.g. tens 4, ones 2 -> 42).
//   It is the reverse path of the binary->tens/ones splitter that feeds the digit display.
//   It sits between the keypad/digit source and any logic that needs a binary operand.
//   A lone digit followed by a timeout is committed as a partial entry.
// PARAMETERS
//   NDIG     2     digits per complete entry (1..4)
//   WIDTH    6     width of binary output value
//   MAXVAL   63    largest legal value; larger entries are rejected; MAXVAL < 2**WIDTH
//   TIMEOUT  1000  idle cycles in COLLECT before a partial entry is committed (>=2)
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   clear        in   1       synchronous abort of the entry in progress
//   digit_valid  in   1       digit is sampled on every clk edge where this is high
//   digit        in   4       BCD digit; legal values are 0..9
//   value        out  WIDTH   last committed binary value; holds between commits
//   value_valid  out  1       one-cycle pulse; value has just been updated
//   err          out  1       one-cycle pulse; entry rejected (bad digit or > MAXVAL)
//   busy         out  1       high while in COLLECT
//   digit_cnt    out  3       digits accepted in the current entry
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=IDLE; acc=0; digit_cnt=0; value=0; value_valid=0; err=0; busy=0.
//   All outputs are registered. value_valid and err default to 0 every cycle.
//   acc is internal and 4*NDIG bits wide; acc_next = acc*10 + digit.
//   IDLE:
//     - digit_valid with digit<=9: acc<=digit; digit_cnt<=1.
//       If NDIG==1, commit. Otherwise -> COLLECT and clear the timer.
//     - digit_valid with digit>9: err pulse; stay in IDLE.
//   COLLECT:
//     - Legal digit: acc<=acc_next; digit_cnt+1; clear the timer.
//       If digit_cnt+1==NDIG, commit using acc_next.
//     - Illegal digit (>9): err pulse; acc and digit_cnt<=0; -> IDLE.
//       The partial entry is discarded.
//     - No digit: the timer increments. When it reaches TIMEOUT-1, commit the current acc.
//   Commit (same edge as the final digit or the timeout):
//     - If the candidate is <= MAXVAL: value<=candidate; value_valid<=1.
//     - Otherwise: err<=1 and value unchanged.
//     - Always: acc and digit_cnt<=0; -> IDLE.
//   Latency: value_valid is high in the cycle immediately after the clk edge that
//     sampled the final digit.
//   A new digit may be presented in the first cycle after a commit; it starts a new entry.
//   clear has priority over digit_valid and over the timeout:
//     - -> IDLE; acc and digit_cnt<=0.
//     - value is kept; no pulses.
//   busy = (state==COLLECT).
//   Reset asserted mid-entry: the partial entry is lost; value returns to 0.
// TESTING
//   1. Reset, then digits 4 then 2 on consecutive cycles
//      -> value=42 and value_valid pulses for 1 cycle, one cycle after the '2' edge.
//   2. Digits 6, 4 (64 > MAXVAL=63)
//      -> err pulses; value keeps its prior 42; value_valid stays 0.
//   3. Digit 7, then idle for TIMEOUT cycles -> value=7, value_valid pulse, busy falls.
//      Repeat with clear asserted at cycle 500 -> no pulse; back to IDLE.
//   4. Digit 3, then digit 4'hB -> err pulse; digit_cnt=0.
//      Next entry 1,5 -> value=15.
//   5. clear and digit_valid(5) on the same edge in COLLECT -> clear wins; digit_cnt=0.
//      Also: drop rst_n while digit_cnt=1 -> all outputs return to reset values at once,
//      without waiting for clk.
//   6. Back-to-back entries 0,9 then 6,3 with no gap
//      -> value=9 then value=63, with two value_valid pulses 2 cycles apart.

Source files
------------

// File: rtl/bcd_digit_to_bin_if.sv
// Digit-entry bus between a keypad/digit source and the BCD-to-binary decoder.
// The master drives digits and the abort; the slave returns the committed value,
// the commit/reject pulses and progress status.
interface bcd_digit_to_bin_if #(
  parameter int WIDTH = 6
);
  logic             clear;
  logic             digit_valid;
  logic [3:0]       digit;
  logic [WIDTH-1:0] value;
  logic             value_valid;
  logic             err;
  logic             busy;
  logic [2:0]       digit_cnt;

  modport master (
    output clear, digit_valid, digit,
    input  value, value_valid, err, busy, digit_cnt
  );

  modport slave (
    input  clear, digit_valid, digit,
    output value, value_valid, err, busy, digit_cnt
  );
endinterface

// File: rtl/bcd_digit_to_bin.sv
// Decimal-digit entry decoder: accumulates BCD digits (most significant first)
// into a binary value. A full entry commits on its last digit; a partial entry
// commits after TIMEOUT idle cycles. Oversized values and non-BCD digits are
// rejected with a one-cycle err pulse; the last good value is held.
module bcd_digit_to_bin #(
  parameter int NDIG    = 2,
  parameter int WIDTH   = 6,
  parameter int MAXVAL  = 63,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_digit_to_bin_if.slave    bus
);

  // Accumulator holds up to NDIG decimal digits; the extended width keeps
  // acc*10+digit exact before the range check.
  localparam int ACC_W = 4 * NDIG;
  localparam int EXT_W = ACC_W + 4;
  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [2:0]       cnt_q;
  logic [TMR_W-1:0] tmr_q;
  logic [WIDTH-1:0] value_q;
  logic             vv_q;
  logic             err_q;

  logic             digit_ok;
  logic             last_digit;
  logic             tmr_done;
  logic             commit_c;
  logic             cand_ok;
  logic [2:0]       cnt_inc;
  logic [EXT_W-1:0] acc_next_ext;
  logic [EXT_W-1:0] cand_c;

  // Commit decision and candidate value; clear suppresses any commit.
  always_comb begin
    digit_ok     = (bus.digit <= 4'd9);
    acc_next_ext = EXT_W'(acc_q) * EXT_W'(10) + EXT_W'(bus.digit);
    cnt_inc      = cnt_q + 3'd1;
    last_digit   = (cnt_inc == 3'(NDIG));
    tmr_done     = (tmr_q == TMR_W'(TIMEOUT - 1));
    commit_c     = 1'b0;
    cand_c       = EXT_W'(acc_q);
    if (!bus.clear) begin
      if (bus.digit_valid && digit_ok) begin
        if (state_q == S_IDLE) begin
          // Single-digit entries complete on their first digit.
          if (NDIG == 1) begin
            commit_c = 1'b1;
            cand_c   = EXT_W'(bus.digit);
          end
        end else if (last_digit) begin
          commit_c = 1'b1;
          cand_c   = acc_next_ext;
        end
      end else if (!bus.digit_valid && (state_q == S_COLLECT) && tmr_done) begin
        // Timeout: commit the partial entry as it stands.
        commit_c = 1'b1;
      end
    end
    cand_ok = (32'(cand_c) <= 32'(MAXVAL));
  end

  // Entry FSM with registered value, pulses and progress state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      value_q <= '0;
      vv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vv_q  <= 1'b0;
      err_q <= 1'b0;
      if (commit_c) begin
        if (cand_ok) begin
          value_q <= WIDTH'(cand_c);
          vv_q    <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
        acc_q   <= '0;
        cnt_q   <= '0;
        tmr_q   <= '0;
        state_q <= S_IDLE;
      end else if (bus.clear) begin
        // Abort: drop the entry silently, keep the last committed value.
        acc_q   <= '0;
        cnt_q   <= '0;
        tmr_q   <= '0;
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.digit_valid) begin
              if (digit_ok) begin
                acc_q   <= ACC_W'(bus.digit);
                cnt_q   <= 3'd1;
                tmr_q   <= '0;
                state_q <= S_COLLECT;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_COLLECT: begin
            if (bus.digit_valid) begin
              if (digit_ok) begin
                acc_q <= acc_next_ext[ACC_W-1:0];
                cnt_q <= cnt_inc;
                tmr_q <= '0;
              end else begin
                // Bad digit discards the whole partial entry.
                err_q   <= 1'b1;
                acc_q   <= '0;
                cnt_q   <= '0;
                tmr_q   <= '0;
                state_q <= S_IDLE;
              end
            end else begin
              tmr_q <= tmr_q + TMR_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = vv_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q == S_COLLECT);
  assign bus.digit_cnt   = cnt_q;

endmodule

// File: tb/tb_bcd_digit_to_bin.sv
// Directed bench for bcd_digit_to_bin: expected commits/rejects are queued when
// digits are driven and matched (kind, cycle, value) when the DUT pulses.
module tb_bcd_digit_to_bin;
  localparam int NDIG    = 2;
  localparam int WIDTH   = 6;
  localparam int MAXVAL  = 63;
  localparam int TIMEOUT = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bcd_digit_to_bin_if #(.WIDTH(WIDTH)) bif ();

  bcd_digit_to_bin #(
    .NDIG(NDIG), .WIDTH(WIDTH), .MAXVAL(MAXVAL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             is_err;
    logic [WIDTH-1:0] val;   // value expected on the bus at the pulse
    int               cyc;   // cycle count at which the pulse is sampled
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_err, input int v, input int c);
    exp_t e;
    e.is_err = is_err;
    e.val    = WIDTH'(v);
    e.cyc    = c;
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] d);
    @(negedge clk);
    bif.clear       = 1'b0;
    bif.digit_valid = 1'b1;
    bif.digit       = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bif.clear       = 1'b0;
      bif.digit_valid = 1'b0;
      bif.digit       = 4'd0;
    end
  endtask

  // Scoreboard side: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && (bif.value_valid || bif.err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, bif.value_valid, bif.err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_err", bif.err, e.is_err);
        chk("pulse_vv", bif.value_valid, !e.is_err);
        chk("pulse_value", bif.value, e.val);
      end
    end
  end

  initial begin
    bif.clear       = 1'b0;
    bif.digit_valid = 1'b0;
    bif.digit       = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_value", bif.value, 0);
    chk("rst_vv", bif.value_valid, 0);
    chk("rst_err", bif.err, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_cnt", bif.digit_cnt, 0);
    rst_n = 1'b1;

    // 4,2 -> 42
    send(4'd4);
    send(4'd2);
    chk("t1_busy_mid", bif.busy, 1);
    chk("t1_cnt_mid", bif.digit_cnt, 1);
    push(1'b0, 42, cyc + 1);
    idle(1);
    chk("t1_busy_after", bif.busy, 0);
    chk("t1_cnt_after", bif.digit_cnt, 0);
    idle(1);
    chk("t1_vv_one_cycle", bif.value_valid, 0);
    chk("t1_value_hold", bif.value, 42);

    // 6,4 -> 64 > MAXVAL, rejected; 42 held
    send(4'd6);
    send(4'd4);
    push(1'b1, 42, cyc + 1);
    idle(2);
    chk("t2_value_hold", bif.value, 42);

    // 7 then timeout -> 7
    send(4'd7);
    push(1'b0, 7, cyc + 1 + TIMEOUT);
    idle(TIMEOUT);
    chk("t3_busy_before_to", bif.busy, 1);
    chk("t3_vv_before_to", bif.value_valid, 0);
    idle(1);
    chk("t3_busy_after_to", bif.busy, 0);
    chk("t3_value", bif.value, 7);

    // 7 then clear at idle cycle 500 -> no commit
    send(4'd7);
    idle(499);
    @(negedge clk);
    bif.clear = 1'b1;
    idle(1);
    chk("t3c_busy", bif.busy, 0);
    chk("t3c_cnt", bif.digit_cnt, 0);
    idle(TIMEOUT + 5);
    chk("t3c_value_hold", bif.value, 7);

    // 3, B -> reject, then 1,5 -> 15
    send(4'd3);
    send(4'hB);
    push(1'b1, 7, cyc + 1);
    idle(1);
    chk("t4_cnt", bif.digit_cnt, 0);
    chk("t4_busy", bif.busy, 0);
    send(4'hC);
    push(1'b1, 7, cyc + 1);
    send(4'd1);
    send(4'd5);
    push(1'b0, 15, cyc + 1);
    idle(1);
    chk("t4_value", bif.value, 15);

    // clear and digit on the same edge in COLLECT -> clear wins
    send(4'd8);
    @(negedge clk);
    bif.clear       = 1'b1;
    bif.digit_valid = 1'b1;
    bif.digit       = 4'd5;
    idle(1);
    chk("t5_cnt", bif.digit_cnt, 0);
    chk("t5_busy", bif.busy, 0);
    idle(3);
    chk("t5_value_hold", bif.value, 15);

    // async reset mid-entry
    send(4'd2);
    idle(1);
    chk("t5r_cnt_pre", bif.digit_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5r_value", bif.value, 0);
    chk("t5r_cnt", bif.digit_cnt, 0);
    chk("t5r_busy", bif.busy, 0);
    chk("t5r_vv", bif.value_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back 0,9 then 6,3 (63 == MAXVAL accepted)
    send(4'd0);
    send(4'd9);
    push(1'b0, 9, cyc + 1);
    send(4'd6);
    send(4'd3);
    push(1'b0, 63, cyc + 1);
    idle(2);
    chk("t6_value", bif.value, 63);

    // 9,9 -> 99 rejected, 63 held
    send(4'd9);
    send(4'd9);
    push(1'b1, 63, cyc + 1);
    idle(3);

    repeat (20) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
